// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational alu32 between two requesters.
// Requester 0 is the execute stage and requester 1 is the address/branch helper.
// Pipeline: S1 is the operand register that drives alu_*. S2 is the response register (rsp_*).
// Each response carries the ID of the requester that issued it.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN.
//   Defined:   requester 0 always wins contention.
//   Undefined: round-robin on contention, with requester 0 first after reset.
module alu_share_arb #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [4:0]        req0_shamt,
    input  logic [4:0]        req1_shamt,
    input  logic [3:0]        req0_f,
    input  logic [3:0]        req1_f,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic [3:0]        alu_f,
    output logic              alu_blez,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_zero,
    input  logic              alu_blez_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_zero,
    output logic              rsp_blez
);

    // S1: operand stage
    logic              s1_valid_q, s1_valid_d;
    logic              s1_id_q, s1_id_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [4:0]        alu_shamt_q, alu_shamt_d;
    logic [3:0]        alu_f_q, alu_f_d;

    // S2: response stage
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_y_q, rsp_y_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_blez_q, rsp_blez_d;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // ID of the most recent accepted request. Reset to 1 so that requester 0 wins first.
    logic              last_id_q, last_id_d;
`endif

    logic       s2_adv;
    logic       s1_adv;
    logic [1:0] grant;

    assign s2_adv = !rsp_valid_q || rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    // Grant selection: a lone requester always wins; contention is resolved by priority mode
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11: grant = 2'b01;
`else
            2'b11: grant = last_id_q ? 2'b01 : 2'b10;
`endif
            default: grant = 2'b00;
        endcase
    end

    // A grant becomes a handshake only when S1 can take the operands this cycle
    assign req_ready = grant & {2{s1_adv}};

    // Next-state for both pipeline stages and the arbitration pointer
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_shamt_d = alu_shamt_q;
        alu_f_d     = alu_f_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_blez_d  = rsp_blez_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_id_d   = last_id_q;
`endif

        // S2 captures whatever S1 currently presents to the ALU; the flags pass through unmodified
        if (s2_adv) begin
            rsp_valid_d = s1_valid_q;
            rsp_id_d    = s1_id_q;
            rsp_y_d     = alu_y;
            rsp_zero_d  = alu_zero;
            rsp_blez_d  = alu_blez_out;
        end

        // S1 takes the granted operands. When nothing is granted, the ALU inputs keep their
        // old values so that the ALU does not toggle.
        if (s1_adv) begin
            s1_valid_d = |grant;
            if (|grant) begin
                s1_id_d = grant[1];
                if (grant[1]) begin
                    alu_a_d     = req1_a;
                    alu_b_d     = req1_b;
                    alu_shamt_d = req1_shamt;
                    alu_f_d     = req1_f;
                end else begin
                    alu_a_d     = req0_a;
                    alu_b_d     = req0_b;
                    alu_shamt_d = req0_shamt;
                    alu_f_d     = req0_f;
                end
`ifndef ALU_ARB_FIXED_PRIO_EN
                last_id_d = grant[1];
`endif
            end
        end
    end

    // State registers; an asynchronous reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_shamt_q <= '0;
            alu_f_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_blez_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_id_q   <= 1'b1;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_shamt_q <= alu_shamt_d;
            alu_f_q     <= alu_f_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_blez_q  <= rsp_blez_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_id_q   <= last_id_d;
`endif
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_shamt = alu_shamt_q;
    assign alu_f     = alu_f_q;
    assign alu_blez  = 1'b0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_blez  = rsp_blez_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed test of alu_share_arb with a small combinational alu32 stand-in.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns after the falling edge.
module tb_alu_share_arb;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]        req0_shamt, req1_shamt;
    logic [3:0]        req0_f, req1_f;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [4:0]        alu_shamt;
    logic [3:0]        alu_f;
    logic              alu_blez;
    logic [DATA_W-1:0] alu_y;
    logic              alu_zero;
    logic              alu_blez_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_y;
    logic              rsp_zero;
    logic              rsp_blez;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_share_arb #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req0_shamt   (req0_shamt),
        .req1_shamt   (req1_shamt),
        .req0_f       (req0_f),
        .req1_f       (req1_f),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_shamt    (alu_shamt),
        .alu_f        (alu_f),
        .alu_blez     (alu_blez),
        .alu_y        (alu_y),
        .alu_zero     (alu_zero),
        .alu_blez_out (alu_blez_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_y        (rsp_y),
        .rsp_zero     (rsp_zero),
        .rsp_blez     (rsp_blez)
    );

    always #5 clk = ~clk;

    // alu32 stand-in: AND, OR, ADD, SUB, SLL (B << shamt), SLT.
    // blez_out is set when the result is <= 0.
    always_comb begin
        alu_y = '0;
        case (alu_f)
            4'b0000: alu_y = alu_a & alu_b;
            4'b0001: alu_y = alu_a | alu_b;
            4'b0010: alu_y = alu_a + alu_b;
            4'b0110: alu_y = alu_a - alu_b;
            4'b0101: alu_y = alu_b << alu_shamt;
            4'b0111: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = '0;
        endcase
        alu_zero     = (alu_y == '0);
        alu_blez_out = (alu_y == '0) || alu_y[DATA_W-1];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    // Advance one full cycle and return 1 ns after the next falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid  = 2'b00;
        req0_a = '0; req0_b = '0; req0_shamt = '0; req0_f = '0;
        req1_a = '0; req1_b = '0; req1_shamt = '0; req1_f = '0;
        rsp_ready  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_req0(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh, input logic [3:0] f);
        req0_a = a; req0_b = b; req0_shamt = sh; req0_f = f;
    endtask

    task automatic set_req1(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh, input logic [3:0] f);
        req1_a = a; req1_b = b; req1_shamt = sh; req1_f = f;
    endtask

    initial begin
        int idx;
        clear_inputs();
        rst_n = 1'b0;

        // Reset state: all outputs are 0 while reset is held
        #7;
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_y",     rsp_y,               32'd0);
        check_eq("rst_rsp_id",    {31'd0, rsp_id},     32'd0);
        check_eq("rst_alu_a",     alu_a,               32'd0);
        check_eq("rst_alu_f",     {28'd0, alu_f},      32'd0);
        check_eq("rst_req_ready", {30'd0, req_ready},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Single op: 5 + 3 on requester 0. The result appears two edges after the request.
        set_req0(32'd5, 32'd3, 5'd0, 4'b0010);
        req_valid = 2'b01;
        #0;
        check_eq("single_ready", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00;
        check_eq("single_s1_alu_a", alu_a, 32'd5);
        check_eq("single_s1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        check_eq("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("single_rsp_y",     rsp_y,              32'd8);
        check_eq("single_rsp_id",    {31'd0, rsp_id},    32'd0);
        check_eq("single_rsp_zero",  {31'd0, rsp_zero},  32'd0);
        check_eq("alu_blez_tied",    {31'd0, alu_blez},  32'd0);
        step();
        check_eq("single_drain", {31'd0, rsp_valid}, 32'd0);

        // Contention with round-robin: grants 0,1,0,1; responses 0 (zero=1) and 9 alternate
        do_reset();
        set_req0(32'd1, 32'd1, 5'd0, 4'b0110);
        set_req1(32'd7, 32'd2, 5'd0, 4'b0010);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) req_valid = 2'b00;
            #0;
            if (k < 4)
                check_eq($sformatf("cont_grant%0d", k), {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            else
                check_eq($sformatf("cont_idle%0d", k), {30'd0, req_ready}, 32'd0);
            if (k >= 2) begin
                idx = k - 2;
                check_eq($sformatf("cont_rsp_valid%0d", idx), {31'd0, rsp_valid}, 32'd1);
                check_eq($sformatf("cont_rsp_id%0d", idx),    {31'd0, rsp_id},    (idx % 2 == 1) ? 32'd1 : 32'd0);
                check_eq($sformatf("cont_rsp_y%0d", idx),     rsp_y,              (idx % 2 == 1) ? 32'd9 : 32'd0);
                check_eq($sformatf("cont_rsp_zero%0d", idx),  {31'd0, rsp_zero},  (idx % 2 == 1) ? 32'd0 : 32'd1);
            end
            step();
        end

        // Backpressure: two requests are accepted, then ready drops. Releasing the stall drains in order.
        do_reset();
        rsp_ready = 1'b0;
        set_req0(32'd10, 32'd1, 5'd0, 4'b0010);
        req_valid = 2'b01;
        #0;
        check_eq("bp_accept0", {30'd0, req_ready}, 32'd1);
        step();
        set_req0(32'd20, 32'd2, 5'd0, 4'b0010);
        #0;
        check_eq("bp_accept1", {30'd0, req_ready}, 32'd1);
        step();
        set_req0(32'd30, 32'd3, 5'd0, 4'b0010);
        #0;
        check_eq("bp_full_ready", {30'd0, req_ready}, 32'd0);
        check_eq("bp_full_rsp_y", rsp_y, 32'd11);
        step();
        check_eq("bp_still_full", {30'd0, req_ready}, 32'd0);
        check_eq("bp_hold_rsp_y", rsp_y, 32'd11);
        check_eq("bp_hold_alu_a", alu_a, 32'd20);
        rsp_ready = 1'b1;
        #0;
        check_eq("bp_release_ready", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00;
        check_eq("bp_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("bp_rsp1_y", rsp_y, 32'd22);
        step();
        check_eq("bp_rsp2_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("bp_rsp2_y", rsp_y, 32'd33);
        step();
        check_eq("bp_empty", {31'd0, rsp_valid}, 32'd0);

        // Shift and flags
        do_reset();
        set_req1(32'd0, 32'h1, 5'd4, 4'b0101);
        req_valid = 2'b10;
        #0;
        check_eq("sh_ready1", {30'd0, req_ready}, 32'd2);
        step();
        set_req0(32'h8000_0000, 32'd0, 5'd0, 4'b0000);
        req_valid = 2'b01;
        #0;
        check_eq("and_ready0", {30'd0, req_ready}, 32'd1);
        step();
        req_valid = 2'b00;
        check_eq("sh_rsp_y",  rsp_y,              32'h10);
        check_eq("sh_rsp_id", {31'd0, rsp_id},    32'd1);
        step();
        check_eq("and_rsp_y",    rsp_y,              32'd0);
        check_eq("and_rsp_zero", {31'd0, rsp_zero},  32'd1);
        check_eq("and_rsp_blez", {31'd0, rsp_blez},  32'd1);
        check_eq("and_rsp_id",   {31'd0, rsp_id},    32'd0);

        // Reset mid-flight: both stages are full when reset is pulsed between edges
        do_reset();
        set_req0(32'd5, 32'd3, 5'd0, 4'b0010);
        req_valid = 2'b01;
        step();
        set_req0(32'd6, 32'd6, 5'd0, 4'b0010);
        step();
        req_valid = 2'b00;
        check_eq("mid_pre_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("mid_rst_rsp_y",     rsp_y,              32'd0);
        check_eq("mid_rst_alu_a",     alu_a,              32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        set_req1(32'd7, 32'd2, 5'd0, 4'b0010);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        check_eq("mid_new_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("mid_new_rsp_id",    {31'd0, rsp_id},    32'd1);
        check_eq("mid_new_rsp_y",     rsp_y,              32'd9);

        // Priority mode with both requesters continuously valid
        do_reset();
        set_req0(32'd1, 32'd2, 5'd0, 4'b0010);
        set_req1(32'd3, 32'd4, 5'd0, 4'b0010);
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #0;
`ifdef ALU_ARB_FIXED_PRIO_EN
            check_eq($sformatf("prio_fixed%0d", k), {30'd0, req_ready}, 32'd1);
`else
            check_eq($sformatf("prio_rr%0d", k), {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
`endif
            step();
        end
        req_valid = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and pipeline sequencer that shares one `alu32` instance between a primary requester (port 0, execute stage) and a secondary requester (port 1, address/branch helper). It grants one operation per cycle using valid/ready handshakes. Operands are registered into the ALU, the ALU outputs are registered into a response stage, and each result is returned with the ID of the requester that issued it. The block sits between the requesters and `alu32`; the ALU itself stays purely combinational.

## Interface
- `DATA_W`, 32, operand/result width; must equal the `alu32` width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i is requester i.
- `req_ready`  out  2  per-requester ready; at most one bit high per cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  DATA_W each  operands.
- `req0_shamt`, `req1_shamt`  in  5 each  shift amounts.
- `req0_f`, `req1_f`  in  4 each  ALU function codes.
- `alu_a`, `alu_b`  out  DATA_W  to `alu32` A/B.
- `alu_shamt`  out  5  to `alu32` shamt1.
- `alu_f`  out  4  to `alu32` F.
- `alu_blez`  out  1  to `alu32` blez; tied 0.
- `alu_y`  in  DATA_W  from `alu32` Y.
- `alu_zero`  in  1  from `alu32` zero.
- `alu_blez_out`  in  1  from `alu32` blez_out.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  1  requester that issued the response.
- `rsp_y`  out  DATA_W  registered ALU result.
- `rsp_zero`, `rsp_blez`  out  1 each  registered ALU flags.

## Operation
- **Pipeline stages**
  - S1 is the operand register: `s1_valid`, `s1_id`, and the `alu_*` outputs.
  - S2 is the response register: the `rsp_*` outputs.
- **S2 control**
  - `s2_adv = !rsp_valid || rsp_ready`.
  - On `s2_adv`, S2 loads `{s1_valid, s1_id, alu_y, alu_zero, alu_blez_out}`.
- **S1 control**
  - `s1_adv = !s1_valid || s2_adv`.
  - On `s1_adv`, S1 loads the granted request's operands, or clears `s1_valid` when nothing is granted.
- **Arbitration** (combinational from `req_valid` and `last_id`)
  - One requester valid: that requester is granted.
  - Both valid: the requester `!last_id` is granted.
  - `req_ready[i] = grant[i] && s1_adv`.
- **Pointer update**
  - `last_id` updates to the granted ID only on a completed handshake (`req_valid[i] && req_ready[i]`).
  - A valid request that is not granted does not change `last_id`.
- **Operand holding**
  - `alu_*` outputs hold their last values while S1 is stalled or empty. No zeroing after accept.
- **Ordering**
  - Responses are delivered in acceptance order.
  - No request is dropped or duplicated under any backpressure pattern.
- **Arithmetic**
  - Flags are taken from `alu32` unmodified; no width conversion.
  - `alu_blez` is constant 0.

## Timing
- **Reset values**
  - All outputs 0: `rsp_valid`, `rsp_id`, `rsp_y`, `rsp_zero`, `rsp_blez`, `alu_a`, `alu_b`, `alu_shamt`, `alu_f`.
  - `s1_valid = 0`.
  - `last_id = 1`, so requester 0 wins the first contention.
- **Latency**
  - A handshake at edge N gives `rsp_valid` = 1 with the result after edge N+1 (visible in cycle N+1 to N+2), provided `rsp_ready` was high.
  - Two-cycle request-to-response latency.
- **Throughput**
  - One accept per cycle while `rsp_ready` = 1.
  - With `rsp_ready` = 0: at most 2 requests in flight; `req_ready` = 0 once S1 and S2 are both full.
- **Simultaneous events**
  - Both requesters valid and `s1_adv` = 1: exactly one `req_ready` bit is high.
  - When S2 drains in the same cycle that S1 is full and a request is granted, all three transfers occur on that edge.
- **Requester-side rules**
  - `req_valid` may drop without a handshake; the block keeps no state for it.
  - Requesters must hold operands stable while `req_valid` is high and `req_ready` is low.
- **Reset mid-operation**
  - Asserting `rst_n` low clears both stages immediately, asynchronously.
  - In-flight results are discarded. `rsp_valid` falls without waiting for a clock.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined:
  - Requester 0 always wins contention.
  - `last_id` is not implemented; the first-grant reset rule is moot.
- Not defined: round-robin arbitration as described under Operation.

## Test plan
- **Single op:** reset, then req0 `A=5, B=3, F=4'b0010` held until handshake, `rsp_ready=1` → `rsp_valid` two edges later with `rsp_y=8`, `rsp_id=0`, `rsp_zero=0`.
- **Contention, round-robin:** both requesters valid continuously for 4 accepts (req0 `A=1,B=1,F=0110`; req1 `A=7,B=2,F=0010`) → grants 0,1,0,1; responses `y=0` with `zero=1`, then `y=9`, alternating.
- **Backpressure:** hold `rsp_ready=0`, req0 valid for 3 ops → exactly 2 accepted, then `req_ready=2'b00`; raise `rsp_ready` → all 3 responses delivered in order with nothing lost.
- **Shift and flags:** req1 `B=32'h1, shamt=4, F=4'b0101` → `rsp_y=32'h10`; req0 `A=32'h8000_0000, F=0000, B=0` → `rsp_zero=1`, `rsp_blez=1`.
- **Reset mid-flight:** two ops in flight, pulse `rst_n` low between edges → all outputs 0 immediately; after release, a new req1 op completes with `rsp_id=1`.
- **Fixed priority:** build with `ALU_ARB_FIXED_PRIO_EN`, both requesters valid for 3 cycles → req0 granted every cycle and `req_ready[1]` stays 0.
